// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage types and constants
package if_stage_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR          = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with a one-entry fetch buffer
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        REDIRECT_EN,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic [31:0] IF_PC_PLUS4,
    output logic        IF_VALID
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc4_q, if_pc4_d;
    logic         if_valid_q, if_valid_d;
    logic         load;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt = REDIRECT_PC & ~32'h0000_0003;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_pc4_d   = if_pc4_q;
        load       = 1'b0;
        IMEM_REQ   = 1'b0;
        IMEM_ADDR  = pc_q;

        case (state_q)
            FETCH_IDLE: begin
                // Only issue when the buffer is empty or being consumed this edge
                IMEM_REQ  = (!if_valid_q || !STALL) && !REDIRECT_EN && !RST;
                IMEM_ADDR = pc_q;
                if (REDIRECT_EN) begin
                    pc_d = redirect_tgt;
                end else if (IMEM_REQ) begin
                    if (IMEM_READY) begin
                        load       = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = IMEM_RDATA;
                        if_pc4_d   = pc_q + PC_INCR;
                        pc_d       = pc_q + PC_INCR;
                    end else begin
                        req_addr_d = pc_q;
                        state_d    = FETCH_BUSY;
                    end
                end
            end
            FETCH_BUSY: begin
                IMEM_REQ  = !RST;
                IMEM_ADDR = req_addr_q;
                if (REDIRECT_EN) begin
                    pc_d    = redirect_tgt;
                    state_d = IMEM_READY ? FETCH_IDLE : FETCH_DRAIN;
                end else if (IMEM_READY) begin
                    load       = 1'b1;
                    if_pc_d    = req_addr_q;
                    if_instr_d = IMEM_RDATA;
                    if_pc4_d   = req_addr_q + PC_INCR;
                    pc_d       = req_addr_q + PC_INCR;
                    state_d    = FETCH_IDLE;
                end
            end
            FETCH_DRAIN: begin
                IMEM_REQ  = !RST;
                IMEM_ADDR = req_addr_q;
                if (REDIRECT_EN) pc_d = redirect_tgt;
                if (IMEM_READY) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (REDIRECT_EN)  if_valid_d = 1'b0;
        else if (load)    if_valid_d = 1'b1;
        else if (!STALL)  if_valid_d = 1'b0;
        else              if_valid_d = if_valid_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
            if_pc4_q   <= 32'h0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_pc4_q   <= if_pc4_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign IF_PC          = if_pc_q;
    assign IF_INSTRUCTION = if_instr_q;
    assign IF_PC_PLUS4    = if_pc4_q;
    assign IF_VALID       = if_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

    localparam logic [31:0] DATA_KEY = 32'h5A5A_5A5A;

    logic        CLK = 1'b0;
    logic        RST = 1'b1, STALL = 1'b0, REDIRECT_EN = 1'b0, IMEM_READY = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        IMEM_REQ, IF_VALID;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, IF_PC, IF_INSTRUCTION, IF_PC_PLUS4;

    logic        RST1 = 1'b1, READY1 = 1'b0, STALL1 = 1'b0, REDIR1 = 1'b0;
    logic [31:0] REDIR_PC1 = 32'h0;
    logic        REQ1, VALID1;
    logic [31:0] ADDR1, RDATA1, PC1, INSTR1, PC4_1;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_buf_q[$];

    always #5 CLK = ~CLK;

    assign IMEM_RDATA = IMEM_ADDR ^ DATA_KEY;
    assign RDATA1     = ADDR1 ^ DATA_KEY;

    if_stage dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .REDIRECT_EN(REDIRECT_EN),
        .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READY(IMEM_READY), .IMEM_RDATA(IMEM_RDATA), .IF_PC(IF_PC),
        .IF_INSTRUCTION(IF_INSTRUCTION), .IF_PC_PLUS4(IF_PC_PLUS4), .IF_VALID(IF_VALID)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RST(RST1), .STALL(STALL1), .REDIRECT_EN(REDIR1),
        .REDIRECT_PC(REDIR_PC1), .IMEM_REQ(REQ1), .IMEM_ADDR(ADDR1),
        .IMEM_READY(READY1), .IMEM_RDATA(RDATA1), .IF_PC(PC1),
        .IF_INSTRUCTION(INSTR1), .IF_PC_PLUS4(PC4_1), .IF_VALID(VALID1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory transfers and buffer consumptions are popped against the queues
    always @(negedge CLK) begin
        if (!RST && IMEM_REQ && IMEM_READY) begin
            if (exp_addr_q.size() == 0) chk("unexpected_xfer", IMEM_ADDR, 32'hxxxx_xxxx);
            else chk("xfer_addr", IMEM_ADDR, exp_addr_q.pop_front());
        end
        if (IF_VALID === 1'b1 && !STALL && !REDIRECT_EN) begin
            if (exp_buf_q.size() == 0) begin
                chk("unexpected_buf", IF_PC, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] p;
                p = exp_buf_q.pop_front();
                chk("if_pc", IF_PC, p);
                chk("if_instr", IF_INSTRUCTION, p ^ DATA_KEY);
                chk("if_pc_plus4", IF_PC_PLUS4, p + 32'd4);
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic stl,
                       input logic rd, input logic [31:0] tgt);
        @(posedge CLK); #1;
        RST = rst; IMEM_READY = rdy; STALL = stl; REDIRECT_EN = rd; REDIRECT_PC = tgt;
        @(negedge CLK);
    endtask

    task automatic cyc1(input logic rst, input logic rdy);
        @(posedge CLK); #1;
        RST1 = rst; READY1 = rdy;
        @(negedge CLK);
    endtask

    initial begin
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("rst_req", {31'b0, IMEM_REQ}, 32'h0);
        chk("rst_valid", {31'b0, IF_VALID}, 32'h0);
        chk("rst_if_pc", IF_PC, 32'h0);
        chk("rst_if_pc4", IF_PC_PLUS4, 32'h0);

        // Zero-wait streaming then a 3-cycle wait state at 0x8
        foreach (exp_addr_q[i]) ;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_buf_q.push_back(32'h0);  exp_buf_q.push_back(32'h4);  exp_buf_q.push_back(32'h8);
        cyc(0, 1, 0, 0, 0);
        chk("first_req", {31'b0, IMEM_REQ}, 32'h1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("wait_addr", IMEM_ADDR, 32'h8);
            chk("wait_valid", {31'b0, IF_VALID}, 32'h0);
        end
        cyc(0, 1, 0, 0, 0);
        chk("wait_last_valid", {31'b0, IF_VALID}, 32'h0);

        // Stall holds buffer 0x10 and blocks requests; release issues 0x14 at once
        exp_addr_q.push_back(32'hC); exp_addr_q.push_back(32'h10); exp_addr_q.push_back(32'h14);
        exp_buf_q.push_back(32'hC);  exp_buf_q.push_back(32'h10);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("stall_req", {31'b0, IMEM_REQ}, 32'h0);
            chk("stall_if_pc", IF_PC, 32'h10);
        end
        cyc(0, 1, 0, 0, 0);
        chk("release_addr", IMEM_ADDR, 32'h14);

        // Redirect to 0x200 while busy at 0x20: old request drains then 0x200
        exp_addr_q.push_back(32'h18); exp_addr_q.push_back(32'h1C);
        exp_addr_q.push_back(32'h20); exp_addr_q.push_back(32'h200);
        exp_buf_q.push_back(32'h14); exp_buf_q.push_back(32'h18);
        exp_buf_q.push_back(32'h1C); exp_buf_q.push_back(32'h200);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h200);
        chk("redir_busy_addr", IMEM_ADDR, 32'h20);
        cyc(0, 0, 0, 0, 0);
        chk("drain_addr", IMEM_ADDR, 32'h20);
        chk("drain_valid", {31'b0, IF_VALID}, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("drain_done_valid", {31'b0, IF_VALID}, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("post_drain_addr", IMEM_ADDR, 32'h200);

        // Redirect with READY and STALL together; target low bits dropped
        exp_addr_q.push_back(32'h204); exp_addr_q.push_back(32'h300); exp_addr_q.push_back(32'h400);
        exp_buf_q.push_back(32'h400);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h303);
        cyc(0, 1, 1, 0, 0);
        chk("redir_stall_valid", {31'b0, IF_VALID}, 32'h0);
        chk("redir_stall_addr", IMEM_ADDR, 32'h300);
        cyc(0, 1, 1, 0, 0);
        chk("held_if_pc", IF_PC, 32'h300);
        cyc(0, 1, 1, 1, 32'h400);
        chk("idle_redir_req", {31'b0, IMEM_REQ}, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("flushed_valid", {31'b0, IF_VALID}, 32'h0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_busy_req", {31'b0, IMEM_REQ}, 32'h0);
        chk("addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("buf_q_empty", exp_buf_q.size(), 32'd0);

        // PC wrap and reset-while-busy with RESET_PC = FFFF_FFF8
        repeat (2) cyc1(1, 1);
        chk("w_rst_pc", PC1, 32'h0);
        cyc1(0, 1);
        chk("w_addr0", ADDR1, 32'hFFFF_FFF8);
        cyc1(0, 1);
        chk("w_addr1", ADDR1, 32'hFFFF_FFFC);
        chk("w_pc4_0", PC4_1, 32'hFFFF_FFFC);
        cyc1(0, 1);
        chk("w_addr2", ADDR1, 32'h0);
        chk("w_if_pc", PC1, 32'hFFFF_FFFC);
        chk("w_pc4_wrap", PC4_1, 32'h0);
        cyc1(0, 0);
        chk("w_busy_addr", ADDR1, 32'h4);
        cyc1(1, 0);
        chk("w_rst_req", {31'b0, REQ1}, 32'h0);
        cyc1(0, 0);
        chk("w_after_rst_req", {31'b0, REQ1}, 32'h1);
        chk("w_after_rst_addr", ADDR1, 32'hFFFF_FFF8);
        chk("w_after_rst_valid", {31'b0, VALID1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
